ro_freq_counter: RTL and testbench

Gated ring-oscillator frequency counter sitting directly downstream of a chained delay path (e.g. a 50-stage inverter-path chain). It closes the chain into a ring by driving the chain input with an enabled, inverted copy of the chain output. It then counts oscillation edges over a programmable window of system clocks and hands the count to the readout logic over a valid/ready handshake. Counts shift with path delay, which makes this the measurement stage of the delay-spy sensor.

---
 rtl/ro_meas_pkg.sv | 24 ++
 rtl/ro_sync.sv | 30 +++
 rtl/ro_freq_counter.sv | 134 +++++++++++++
 tb/tb_ro_freq_counter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator measurement stage: FSM states,
// default widths and the drain-length helper.
package ro_meas_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } ro_state_e;

   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned DEF_WIN_W       = 16;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   // Cycles beyond the synchronizer depth that the ring is given to fall low.
   localparam int unsigned DRAIN_EXTRA = 2;

   // DRAIN_CYCLES = SYNC_STAGES + 2: flushes the synchronizer and settles the ring.
   function automatic int unsigned drain_cycles(input int unsigned sync_stages);
      return sync_stages + DRAIN_EXTRA;
   endfunction

endpackage

// File: rtl/ro_sync.sv
// Multi-flop synchronizer for the free-running ring output followed by a
// rising-edge detector. STAGES must be at least 2.
module ro_sync
   import ro_meas_pkg::*;
#(
   parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the asynchronous ring level in and keep the last synced level for edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Gated ring-oscillator frequency counter. Closes a non-inverting delay chain
// into a ring, counts synchronized rising edges over a window of clk cycles and
// offers the count over a valid/ready handshake.
// Optional build macro RO_CNT_SAT_EN: edge counter saturates instead of wrapping.
module ro_freq_counter
   import ro_meas_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned WIN_W       = DEF_WIN_W,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIN_W-1:0] window,
   output logic             ro_drive,
   input  logic             ro_sense,
   output logic             busy,
   output logic [CNT_W-1:0] result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             overflow
);

   localparam int unsigned       DRAIN_CYCLES = drain_cycles(SYNC_STAGES);
   localparam int unsigned       DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD  = DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

   ro_state_e          state_q, state_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               ro_en_q;
   logic               valid_q;
   logic               edge_rise;

   // Ring closure: the chain is non-inverting, so the inversion lives here.
   (* keep = "true" *) logic ro_gate;
   assign ro_gate  = ro_en_q & ~ro_sense;
   assign ro_drive = ro_gate;

   ro_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (ro_sense),
      .rise_o  (edge_rise)
   );

   // Next-state logic: window countdown, edge counting, drain countdown, handshake.
   always_comb begin
      state_d     = state_q;
      win_cnt_d   = win_cnt_q;
      drain_cnt_d = drain_cnt_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               count_d = '0;
               ovf_d   = 1'b0;
               if (window != '0) begin
                  win_cnt_d = window;
                  state_d   = StRun;
               end else begin
                  // Zero window: report an empty count without ever enabling the ring.
                  state_d = StDone;
               end
            end
         end
         StRun: begin
            win_cnt_d = win_cnt_q - WIN_W'(1);
            if (edge_rise) begin
               if (count_q == CNT_MAX) begin
                  ovf_d = 1'b1;
`ifdef RO_CNT_SAT_EN
                  count_d = count_q;
`else
                  count_d = '0;
`endif
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            if (win_cnt_q == WIN_W'(1)) begin
               state_d     = StDrain;
               drain_cnt_d = DRAIN_LOAD;
            end
         end
         StDrain: begin
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
            if (drain_cnt_q == '0) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (result_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; ring enable and valid are decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         win_cnt_q   <= '0;
         drain_cnt_q <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         ro_en_q     <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_cnt_q   <= win_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         ro_en_q     <= (state_d == StRun);
         valid_q     <= (state_d == StDone);
      end
   end

   assign busy         = (state_q != StIdle);
   assign result       = count_q;
   assign result_valid = valid_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: table of measurement vectors against a
// behavioural ring model, plus hand-written backpressure, reset, back-to-back
// and small-counter sequences.
// Ring model: chain delay d time units, clk period 1000, so rising edges of
// ro_sense occur at d*(2r+1) after ro_en rises (at the start-sampling edge B0).
// A rise at time x is counted at edge B(floor(x/1000)+3) and only if that edge
// is a RUN edge (B1..Bwindow). Odd delays keep ring events off clock edges.
module tb_ro_freq_counter;

   localparam int CLK_HALF = 500;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ready;
   logic [15:0] window;
   logic        ro_drive;
   logic        ro_sense = 1'b0;
   logic        busy;
   logic [15:0] result;
   logic        result_valid;
   logic        overflow;

   logic        start4;
   logic [15:0] window4;
   logic        ro_drive4;
   logic        ro_sense4 = 1'b0;
   logic        busy4;
   logic [3:0]  result4;
   logic        result_valid4;
   logic        overflow4;

   int ring_dly = 2999;
   int n_cmp = 0;
   int n_bad = 0;

   ro_freq_counter dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .window       (window),
      .ro_drive     (ro_drive),
      .ro_sense     (ro_sense),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (ready),
      .overflow     (overflow)
   );

   ro_freq_counter #(
      .CNT_W (4)
   ) dut4 (
      .clk          (clk),
      .rst          (rst),
      .start        (start4),
      .window       (window4),
      .ro_drive     (ro_drive4),
      .ro_sense     (ro_sense4),
      .busy         (busy4),
      .result       (result4),
      .result_valid (result_valid4),
      .result_ready (ready),
      .overflow     (overflow4)
   );

   always #(CLK_HALF) clk = ~clk;

   // Transport-delay chains closing each DUT into a ring.
   always @(ro_drive)  ro_sense  <= #(ring_dly) ro_drive;
   always @(ro_drive4) ro_sense4 <= #(ring_dly) ro_drive4;

   typedef struct {
      int win;
      int dly;
      int res;
      bit ovf;
      int vc;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance to the sampling point of the next cycle (away from the clock edge).
   task automatic step();
      @(posedge clk);
      #100;
   endtask

   // Called in cycle 1 of a measurement; returns the cycle in which result_valid is seen.
   task automatic wait_valid(input int win, input int limit, output int cyc,
                             output bit drive_late, output bit busy_drop);
      cyc        = 1;
      drive_late = 1'b0;
      busy_drop  = 1'b0;
      while (!result_valid && cyc < limit) begin
         if (!busy) busy_drop = 1'b1;
         if (ro_drive && cyc > win) drive_late = 1'b1;
         step();
         cyc++;
      end
   endtask

   task automatic run_meas(input string name, input int win, input int dly,
                           input int exp_res, input bit exp_ovf, input int exp_vc);
      int cyc;
      bit drive_late;
      bit busy_drop;
      ring_dly = dly;
      window   = 16'(win);
      ready    = 1'b0;
      start    = 1'b1;
      step();
      start = 1'b0;
      wait_valid(win, 400, cyc, drive_late, busy_drop);
      check({name, " valid_cycle"}, cyc, exp_vc);
      check({name, " result"}, result, exp_res);
      check({name, " overflow"}, overflow, exp_ovf);
      check({name, " busy_in_done"}, busy, 1);
      check({name, " drive_after_window"}, drive_late, 0);
      check({name, " busy_dropped"}, busy_drop, 0);
      ready = 1'b1;
      step();
      ready = 1'b0;
      check({name, " idle_after_handshake"}, {busy, result_valid}, 0);
      repeat (12) step();
   endtask

   initial begin : watchdog
      #(10_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int cyc;
      bit drive_late;
      bit busy_drop;
      bit stable;
      int vcyc[3];
      int vres[3];
      int nv;
      int exp4;

      // window, delay, result, overflow, valid cycle (= window + 5, or 1 for window 0)
      vecs[0] = '{win: 60, dly: 2999, res: 10, ovf: 1'b0, vc: 65};
      vecs[1] = '{win: 0,  dly: 2999, res: 0,  ovf: 1'b0, vc: 1};
      vecs[2] = '{win: 8,  dly: 2999, res: 1,  ovf: 1'b0, vc: 13};
      vecs[3] = '{win: 20, dly: 1999, res: 5,  ovf: 1'b0, vc: 25};
      vecs[4] = '{win: 1,  dly: 2999, res: 0,  ovf: 1'b0, vc: 6};
      vecs[5] = '{win: 30, dly: 4999, res: 3,  ovf: 1'b0, vc: 35};
      vecs[6] = '{win: 5,  dly: 2999, res: 1,  ovf: 1'b0, vc: 10};

      rst     = 1'b1;
      start   = 1'b0;
      ready   = 1'b0;
      window  = '0;
      start4  = 1'b0;
      window4 = '0;
      step();
      step();
      check("reset outputs", {ro_drive, busy, result, result_valid, overflow}, 0);
      rst = 1'b0;
      step();
      check("post-reset outputs", {ro_drive, busy, result, result_valid, overflow}, 0);
      repeat (3) step();

      for (int i = 0; i < 7; i++) begin
         run_meas($sformatf("vec%0d", i), vecs[i].win, vecs[i].dly, vecs[i].res,
                  vecs[i].ovf, vecs[i].vc);
      end

      // Backpressure: hold ready low 20 cycles, pulse start meanwhile.
      ring_dly = 2999;
      window   = 16'd8;
      start    = 1'b1;
      step();
      start = 1'b0;
      wait_valid(8, 100, cyc, drive_late, busy_drop);
      check("bp valid_cycle", cyc, 13);
      stable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         start = (k % 2 == 0);
         step();
         if (result !== 16'd1 || !result_valid || !busy || overflow) stable = 1'b0;
      end
      check("bp stable_while_stalled", stable, 1);
      // start alongside the completing handshake must be ignored
      start = 1'b1;
      ready = 1'b1;
      step();
      ready = 1'b0;
      check("bp idle_after_ready", {busy, result_valid}, 0);
      step();
      start = 1'b0;
      check("bp restart_accepted", busy, 1);
      wait_valid(8, 100, cyc, drive_late, busy_drop);
      check("bp second valid_cycle", cyc, 13);
      check("bp second result", result, 1);
      ready = 1'b1;
      step();
      ready = 1'b0;
      repeat (12) step();

      // Reset in cycle 30 of a 60-cycle window.
      ring_dly = 2999;
      window   = 16'd60;
      start    = 1'b1;
      step();
      start = 1'b0;
      repeat (29) step();
      check("rst partial count", result, 5);
      check("rst ring running", busy, 1);
      rst = 1'b1;
      #1;
      check("rst async outputs", {ro_drive, busy, result, result_valid, overflow}, 0);
      step();
      rst = 1'b0;
      repeat (12) step();
      run_meas("after_rst", 60, 2999, 10, 1'b0, 65);

      // Back-to-back: ready tied high, start held; one IDLE cycle between runs
      // gives a DONE cycle every 14 cycles.
      ring_dly = 2999;
      window   = 16'd8;
      ready    = 1'b1;
      start    = 1'b1;
      step();
      nv = 0;
      for (int c = 1; c <= 41; c++) begin
         if (result_valid && nv < 3) begin
            vcyc[nv] = c;
            vres[nv] = int'(result);
            nv++;
         end
         step();
      end
      start = 1'b0;
      check("b2b valid_count", nv, 3);
      check("b2b idle_between", busy, 0);
      for (int j = 0; j < 3; j++) begin
         if (j < nv) begin
            check($sformatf("b2b valid_cycle%0d", j), vcyc[j], 13 + 14 * j);
            check($sformatf("b2b result%0d", j), vres[j], 1);
         end
      end
      ready = 1'b0;
      repeat (12) step();

      // 4-bit counter, 25 edges in a 100-cycle window.
`ifdef RO_CNT_SAT_EN
      exp4 = 15;
`else
      exp4 = 9;
`endif
      ring_dly = 1999;
      window4  = 16'd100;
      start4   = 1'b1;
      step();
      start4 = 1'b0;
      cyc    = 1;
      while (!result_valid4 && cyc < 300) begin
         step();
         cyc++;
      end
      check("cnt4 valid_cycle", cyc, 105);
      check("cnt4 result", result4, exp4);
      check("cnt4 overflow", overflow4, 1);
      ready = 1'b1;
      step();
      ready = 1'b0;
      check("cnt4 idle", {busy4, result_valid4}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
